// File: rtl/q_proj_pkg.sv
// Shared types and helpers for the Q projection read-back sequencer.
package q_proj_pkg;

  localparam int unsigned Q_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // True when one more read can be issued without the FIFO ever holding more than 2 words.
  function automatic logic credit_ok(input logic [1:0] fifo_cnt,
                                     input logic       rd_pending,
                                     input logic       pop);
    credit_ok = (({1'b0, fifo_cnt} + {2'b00, rd_pending}) < (3'd2 + {2'b00, pop}));
  endfunction

endpackage

// File: rtl/q_rd_fifo.sv
// Two-entry FIFO holding {last, data} read-back words; head is visible while not empty.
module q_rd_fifo #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [1:0]   cnt_q;
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic         push_ok_s;
  logic         pop_ok_s;

  // Push into a full FIFO is only allowed when the head leaves in the same cycle.
  always_comb begin
    pop_ok_s  = pop & (cnt_q != 2'd0);
    push_ok_s = push & ((cnt_q != 2'd2) | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/q_proj_reader.sv
// Read-back sequencer: on start, reads NUM_WORDS words from the result memory
// and streams them out over valid/ready with credit-based flow control.
module q_proj_reader
  import q_proj_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned DATA_W    = Q_DATA_W,
  parameter int unsigned ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              start_err
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  rd_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  accepted_q;
  logic              rd_pend_q;
  logic              rd_last_q;
  logic              busy_q;
  logic              done_q;
  logic              start_err_q;

  logic              pop_s;
  logic              rd_en_s;
  logic              issue_last_s;
  logic              accept_last_s;
  logic              fifo_empty_s;
  logic [1:0]        fifo_cnt_s;
  logic [DATA_W:0]   fifo_head_s;

  // Handshake, read credit and end-of-burst detection.
  always_comb begin
    pop_s = ~fifo_empty_s & out_ready;
    if (state_q == READ) begin
      rd_en_s = credit_ok(fifo_cnt_s, rd_pend_q, pop_s);
    end else begin
      rd_en_s = 1'b0;
    end
    issue_last_s = rd_en_s & (issued_q == LAST_CNT);
    if (state_q == DRAIN) begin
      accept_last_s = pop_s & (accepted_q == LAST_CNT);
    end else begin
      accept_last_s = 1'b0;
    end
  end

  // Burst FSM with counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      rd_pend_q   <= rd_en_s;
      rd_last_q   <= issue_last_s;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= READ;
            addr_q     <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        READ: begin
          start_err_q <= start;
          if (rd_en_s) begin
            issued_q <= issued_q + CNT_W'(1'b1);
            // Address parks on the final word rather than wrapping.
            if (!issue_last_s) begin
              addr_q <= addr_q + ADDR_W'(1'b1);
            end
          end
          if (pop_s) begin
            accepted_q <= accepted_q + CNT_W'(1'b1);
          end
          if (issue_last_s) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          start_err_q <= start;
          if (pop_s) begin
            accepted_q <= accepted_q + CNT_W'(1'b1);
          end
          if (accept_last_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  q_rd_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend_q),
    .push_data({rd_last_q, mem_rd_data}),
    .pop      (pop_s),
    .head     (fifo_head_s),
    .empty    (fifo_empty_s),
    .count    (fifo_cnt_s)
  );

  assign mem_rd_en   = rd_en_s;
  assign mem_rd_addr = addr_q;
  assign out_valid   = ~fifo_empty_s;
  assign out_data    = fifo_head_s[DATA_W-1:0];
  assign out_last    = fifo_head_s[DATA_W] & ~fifo_empty_s;
  assign busy        = busy_q;
  assign done        = done_q;
  assign start_err   = start_err_q;

endmodule
